// File: rtl/pwm_bank.sv
// Eight-channel PWM bank sharing one prescaled counter.
// Optional macro PWM_SHADOW_EN: channel fields are latched per period instead of used live.
module pwm_bank #(
   parameter int unsigned CNT_W    = 8,
   parameter int unsigned PRESCALE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [15:0]      pwm_reg0,
   input  logic [15:0]      pwm_reg1,
   input  logic [15:0]      pwm_reg2,
   input  logic [15:0]      pwm_reg3,
   input  logic [15:0]      pwm_reg4,
   input  logic [15:0]      pwm_reg5,
   input  logic [15:0]      pwm_reg6,
   input  logic [15:0]      pwm_reg7,
   input  logic             sync_clr,
   output logic [7:0]       pwm_out,
   output logic             period_start,
   output logic [CNT_W-1:0] cnt_out
);

   localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [15:0]      w_reg [8];
   logic [7:0]       w_en;
   logic [7:0]       w_inv;
   logic [CNT_W-1:0] w_duty [8];

   logic [7:0]       w_cmp_en;
   logic [7:0]       w_cmp_inv;
   logic [CNT_W-1:0] w_cmp_duty [8];

   logic [PS_W-1:0]  r_presc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_period_start;
   logic [7:0]       r_pwm;

   logic             w_tick;
   logic             w_wrap;
   logic             w_unused_bits;

   assign w_reg[0] = pwm_reg0;
   assign w_reg[1] = pwm_reg1;
   assign w_reg[2] = pwm_reg2;
   assign w_reg[3] = pwm_reg3;
   assign w_reg[4] = pwm_reg4;
   assign w_reg[5] = pwm_reg5;
   assign w_reg[6] = pwm_reg6;
   assign w_reg[7] = pwm_reg7;

   // Bits between the duty field and the control bits carry no meaning.
   assign w_unused_bits = ^{pwm_reg0, pwm_reg1, pwm_reg2, pwm_reg3,
                            pwm_reg4, pwm_reg5, pwm_reg6, pwm_reg7};

   always_comb begin
      w_en  = '0;
      w_inv = '0;
      for (int unsigned n = 0; n < 8; n++) begin
         w_en[n]   = w_reg[n][15];
         w_inv[n]  = w_reg[n][14];
         w_duty[n] = w_reg[n][CNT_W-1:0];
      end
   end

   assign w_tick = (r_presc == PS_W'(PRESCALE - 1));
   assign w_wrap = w_tick && (r_cnt == '1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_presc        <= '0;
         r_cnt          <= '0;
         r_period_start <= 1'b0;
      end else if (sync_clr) begin
         r_presc        <= '0;
         r_cnt          <= '0;
         r_period_start <= 1'b1;
      end else begin
         r_period_start <= w_wrap;
         if (w_tick) begin
            r_presc <= '0;
            r_cnt   <= r_cnt + CNT_W'(1);
         end else begin
            r_presc <= r_presc + PS_W'(1);
         end
      end
   end

`ifdef PWM_SHADOW_EN
   logic             r_first;
   logic [7:0]       r_sh_en;
   logic [7:0]       r_sh_inv;
   logic [CNT_W-1:0] r_sh_duty [8];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_first  <= 1'b1;
         r_sh_en  <= '0;
         r_sh_inv <= '0;
         for (int unsigned n = 0; n < 8; n++) r_sh_duty[n] <= '0;
      end else begin
         r_first <= 1'b0;
         if (r_first || sync_clr || w_wrap) begin
            r_sh_en  <= w_en;
            r_sh_inv <= w_inv;
            for (int unsigned n = 0; n < 8; n++) r_sh_duty[n] <= w_duty[n];
         end
      end
   end

   // Shadows are still zero in the first cycle after reset, so that
   // cycle compares against the live fields it is about to capture.
   always_comb begin
      w_cmp_en  = r_first ? w_en  : r_sh_en;
      w_cmp_inv = r_first ? w_inv : r_sh_inv;
      for (int unsigned n = 0; n < 8; n++)
         w_cmp_duty[n] = r_first ? w_duty[n] : r_sh_duty[n];
   end
`else
   always_comb begin
      w_cmp_en  = w_en;
      w_cmp_inv = w_inv;
      for (int unsigned n = 0; n < 8; n++) w_cmp_duty[n] = w_duty[n];
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pwm <= '0;
      end else begin
         for (int unsigned n = 0; n < 8; n++)
            r_pwm[n] <= w_cmp_en[n] & ((r_cnt < w_cmp_duty[n]) ^ w_cmp_inv[n]);
      end
   end

   assign pwm_out      = r_pwm;
   assign period_start = r_period_start;
   assign cnt_out      = r_cnt;

endmodule

// File: tb/tb_pwm_bank.sv
// Scoreboard bench for pwm_bank: random control words, sync_clr and reset
// checked against a time-based reference model (default build).
module tb_pwm_bank;

   localparam int unsigned W   = 8;
   localparam int unsigned PRE = 4;
   localparam int unsigned PER = 1 << W;

   logic         clk = 1'b0;
   logic         rst;
   logic         sync_clr;
   logic [15:0]  regs [8];
   logic [7:0]   pwm_out;
   logic         period_start;
   logic [W-1:0] cnt_out;

   typedef struct {
      logic [7:0]   pwm;
      logic         ps;
      logic [W-1:0] cnt;
   } exp_t;

   exp_t        q[$];
   int unsigned n_checks = 0;
   int unsigned n_fails  = 0;

   // Model state: clk edges elapsed since the last reset or sync_clr.
   int unsigned k = 0;

   always #5 clk = ~clk;

   pwm_bank #(.CNT_W(W), .PRESCALE(PRE)) dut (
      .clk          (clk),
      .rst          (rst),
      .pwm_reg0     (regs[0]),
      .pwm_reg1     (regs[1]),
      .pwm_reg2     (regs[2]),
      .pwm_reg3     (regs[3]),
      .pwm_reg4     (regs[4]),
      .pwm_reg5     (regs[5]),
      .pwm_reg6     (regs[6]),
      .pwm_reg7     (regs[7]),
      .sync_clr     (sync_clr),
      .pwm_out      (pwm_out),
      .period_start (period_start),
      .cnt_out      (cnt_out)
   );

   function automatic int unsigned cnt_of(input int unsigned kk);
      return (kk / PRE) % PER;
   endfunction

   function automatic logic chan_level(input logic [15:0] word, input int unsigned c);
      int unsigned duty;
      logic        high;
      duty = word % PER;
      high = (c < duty);
      if (!word[15]) return 1'b0;
      return high ^ word[14];
   endfunction

   // Drive one cycle of inputs, push the state expected after the edge.
   task automatic step(input logic r, input logic sc);
      exp_t        e;
      int unsigned c;
      rst      = r;
      sync_clr = sc;
      if (r) begin
         k     = 0;
         e.ps  = 1'b0;
         e.pwm = '0;
      end else begin
         c = cnt_of(k);
         for (int n = 0; n < 8; n++) e.pwm[n] = chan_level(regs[n], c);
         if (sc) begin
            k    = 0;
            e.ps = 1'b1;
         end else begin
            k    = k + 1;
            e.ps = ((k % (PRE * PER)) == 0);
         end
      end
      e.cnt = W'(cnt_of(k));
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int unsigned cycles);
      for (int unsigned i = 0; i < cycles; i++) step(1'b0, 1'b0);
   endtask

   task automatic run_to_cnt(input int unsigned target);
      int unsigned guard = 0;
      while (cnt_of(k) != target && guard < 2 * PRE * PER) begin
         step(1'b0, 1'b0);
         guard++;
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            n_checks++;
            if (cnt_out !== e.cnt) begin
               n_fails++;
               $display("FAIL cnt_out got %h expected %h at %0t", cnt_out, e.cnt, $time);
            end
            n_checks++;
            if (period_start !== e.ps) begin
               n_fails++;
               $display("FAIL period_start got %b expected %b at %0t", period_start, e.ps, $time);
            end
            n_checks++;
            if (pwm_out !== e.pwm) begin
               n_fails++;
               $display("FAIL pwm_out got %b expected %b at %0t", pwm_out, e.pwm, $time);
            end
         end
      end
   end

   initial begin : stimulus
      int unsigned len;
      rst      = 1'b1;
      sync_clr = 1'b0;
      regs[0]  = 16'h8040;
      regs[1]  = 16'hC040;
      regs[2]  = 16'h4040;
      regs[3]  = 16'h8000;
      for (int n = 4; n < 8; n++) regs[n] = 16'($urandom);

      for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
      run(2 * PRE * PER + 20);

      regs[3] = 16'h80FF;
      run(PRE * PER + 30);

      run_to_cnt('h20);
      regs[0] = 16'h8080;
      run(PRE * PER + 30);

      run_to_cnt('h90);
      step(1'b0, 1'b1);
      run(300);

      run_to_cnt('h70);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      run(PRE * PER + 30);

      for (int it = 0; it < 20; it++) begin
         for (int n = 0; n < 8; n++) regs[n] = 16'($urandom);
         if (it == 3) regs[5] = 16'h8000 | 16'(PER - 1);
         if (it == 4) regs[6] = 16'hC000;
         len = $urandom_range(600, 50);
         for (int unsigned c = 0; c < len; c++) begin
            if ($urandom_range(499, 0) == 0) step(1'b1, 1'b0);
            else step(1'b0, ($urandom_range(199, 0) == 0));
         end
      end

      @(negedge clk);
      #1;
      n_checks++;
      if (q.size() != 0) begin
         n_fails++;
         $display("FAIL scoreboard_drain got %0d pending expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
